noc_packet_buffer_node: RTL and testbench
=========================================

Name: noc_packet_buffer_node

Overview:
Store-and-forward packet buffer between a router local port and an endpoint node. Accepts flits on the receive side and queues them in a flit FIFO. Presents flits on the sender side only once a complete packet (header..tail) is buffered. Oversized packets fall back to cut-through so the buffer cannot deadlock. A sticky flag reports framing errors.

Parameters:
DATA_WIDTH, `Noc_Data_Width, flit payload width.
DEPTH, 16, FIFO depth in flits; power of 2, ≥2.
PTR_W, log2(DEPTH), pointer width (derived; not overridden).

Ports:
noc_clk  input  1  clock; all logic on rising edge.
noc_rst_n  input  1  synchronous active-low reset.
receive_valid  input  1  upstream flit valid.
receive_ready  output  1  buffer can accept a flit.
receive_flit  input  DATA_WIDTH  upstream flit payload.
receive_is_header  input  1  flit is the packet header.
receive_is_tail  input  1  flit is the packet tail (header+tail together = single-flit packet).
sender_valid  output  1  head flit is valid for downstream.
sender_ready  input  1  downstream accepts.
sender_flit  output  DATA_WIDTH  head flit payload.
sender_is_header  output  1  head flit header bit.
sender_is_tail  output  1  head flit tail bit.
pkt_count  output  PTR_W+1  number of complete packets (tails) held.
proto_err  output  1  sticky framing-error flag.

Behaviour:
- One clock, synchronous active-low reset. Reset clears wr_ptr, rd_ptr, flit count, pkt_count, both FSMs and proto_err. receive_ready and sender_valid are 0 while noc_rst_n=0. Receive_ready is 1 in the first cycle after reset release.
- Write: wr_fire = receive_valid & receive_ready. Store {flit, is_header, is_tail} at wr_ptr. Pointers wrap modulo DEPTH.
- Read: rd_fire = sender_valid & sender_ready. Advance rd_ptr.
- Occupancy uses a PTR_W+1 count. receive_ready = (count != DEPTH), combinational from registered state. Simultaneous read and write when full is not allowed: ready is already 0.
- sender_flit / sender_is_header / sender_is_tail come combinationally from mem[rd_ptr]. They are stable while sender_valid=1 and sender_ready=0.
- pkt_count: +1 on a wr_fire with is_tail=1, -1 on a rd_fire with is_tail=1. When both happen in the same cycle, pkt_count is unchanged.
- Output FSM:
  - STORE (reset state): sender_valid = (pkt_count != 0). Go to CUT when count == DEPTH and pkt_count == 0, i.e. a packet longer than DEPTH fills the buffer.
  - CUT: sender_valid = (count != 0). Return to STORE on the rd_fire of a flit with is_tail=1.
  - STORE→CUT takes effect the cycle after full is seen. The first CUT-mode flit leaves one cycle later.
- Receive framing FSM (checker only; all flits are stored regardless):
  - EXPECT_HDR (reset state): a wr_fire with is_header=0 sets proto_err. Header with tail=0 → IN_PKT. Header with tail=1 stays in EXPECT_HDR.
  - IN_PKT: a wr_fire with is_header=1 sets proto_err. A tail → EXPECT_HDR.
  - proto_err stays set until reset.
- No combinational path from receive_valid to receive_ready, or from sender_ready to sender_valid.
- Reset mid-packet discards all buffered flits and partial packets. There is no residual output after reset.
- Latency: a single-flit packet written in cycle N gives sender_valid=1 in cycle N+1.

Test Plan:
1. Reset, then one single-flit packet (flit=0xA5, hdr=1, tail=1) written at cycle 0, sender_ready=1 → sender_valid=1 at cycle 1 with flit 0xA5, hdr=1, tail=1; pkt_count goes 1 then back to 0.
2. 4-flit packet sent one flit per cycle, sender_ready=1 → sender_valid stays 0 until the tail is written; flits 0,1,2,3 then emit back-to-back in order with hdr only on the first and tail only on the last.
3. sender_ready=0, stream 4-flit packets (DEPTH=16) → exactly 4 packets accepted; receive_ready=0 at count=16; pkt_count=4. Release ready → 16 flits out, ordering intact across pointer wrap.
4. 20-flit packet with DEPTH=16, sender_ready=1 → buffer fills, FSM enters CUT, all 20 flits delivered, FSM returns to STORE after the tail; no deadlock.
5. Body flit without a preceding header, and separately a header inside an open packet → proto_err=1 and stays 1 until noc_rst_n=0.
6. Reset asserted with 2 packets buffered → next cycle sender_valid=0, pkt_count=0, receive_ready=0. After release, receive_ready=1 and no stale flit appears.

Source files
------------

// File: rtl/noc_packet_buffer_node.sv
// Store-and-forward flit buffer between a router local port and an endpoint.
// Flits are released downstream only once a whole packet is held. A packet
// longer than the buffer switches the output side to cut-through mode.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_packet_buffer_node #(
   parameter  int unsigned DATA_WIDTH = `Noc_Data_Width,
   parameter  int unsigned DEPTH      = 16,
   localparam int unsigned PTR_W      = $clog2(DEPTH)
) (
   input  logic                  noc_clk,
   input  logic                  noc_rst_n,
   input  logic                  receive_valid,
   output logic                  receive_ready,
   input  logic [DATA_WIDTH-1:0] receive_flit,
   input  logic                  receive_is_header,
   input  logic                  receive_is_tail,
   output logic                  sender_valid,
   input  logic                  sender_ready,
   output logic [DATA_WIDTH-1:0] sender_flit,
   output logic                  sender_is_header,
   output logic                  sender_is_tail,
   output logic [PTR_W:0]        pkt_count,
   output logic                  proto_err
);

   localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

   typedef enum logic {ST_STORE, ST_CUT} out_state_t;
   typedef enum logic {FR_EXPECT_HDR, FR_IN_PKT} frame_state_t;

   logic [DATA_WIDTH+1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [PTR_W:0]        count;
   logic [DATA_WIDTH+1:0] head;
   logic                  wr_fire, rd_fire, wr_tail, rd_tail;
   out_state_t            out_state, out_next;
   frame_state_t          fr_state, fr_next;
   logic                  err_set;

   assign head             = mem[rd_ptr];
   assign sender_flit      = head[DATA_WIDTH+1:2];
   assign sender_is_header = head[1];
   assign sender_is_tail   = head[0];

   assign wr_fire = receive_valid & receive_ready;
   assign rd_fire = sender_valid & sender_ready;
   assign wr_tail = wr_fire & receive_is_tail;
   assign rd_tail = rd_fire & sender_is_tail;

   // Flit storage: payload plus framing bits, no reset needed on the array.
   always_ff @(posedge noc_clk) begin
      if (wr_fire) begin
         mem[wr_ptr] <= {receive_flit, receive_is_header, receive_is_tail};
      end
   end

   // Pointers, occupancy and complete-packet count.
   always_ff @(posedge noc_clk) begin
      if (!noc_rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         pkt_count <= '0;
      end else begin
         if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
         if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_fire, rd_fire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         case ({wr_tail, rd_tail})
            2'b10:   pkt_count <= pkt_count + 1'b1;
            2'b01:   pkt_count <= pkt_count - 1'b1;
            default: pkt_count <= pkt_count;
         endcase
      end
   end

   // Output FSM state register.
   always_ff @(posedge noc_clk) begin
      if (!noc_rst_n) out_state <= ST_STORE;
      else            out_state <= out_next;
   end

   // Output FSM: full buffer with no complete packet means an oversized
   // packet, so drain it cut-through until its tail leaves.
   always_comb begin
      out_next      = out_state;
      sender_valid  = 1'b0;
      receive_ready = noc_rst_n && (count != FULL);
      case (out_state)
         ST_STORE: begin
            sender_valid = noc_rst_n && (pkt_count != '0);
            if (count == FULL && pkt_count == '0) out_next = ST_CUT;
         end
         ST_CUT: begin
            sender_valid = noc_rst_n && (count != '0);
            if (rd_tail) out_next = ST_STORE;
         end
         default: out_next = ST_STORE;
      endcase
   end

   // Framing checker state and sticky error flag.
   always_ff @(posedge noc_clk) begin
      if (!noc_rst_n) begin
         fr_state  <= FR_EXPECT_HDR;
         proto_err <= 1'b0;
      end else begin
         fr_state <= fr_next;
         if (err_set) proto_err <= 1'b1;
      end
   end

   // Framing checker: header must open a packet, no header inside one.
   always_comb begin
      fr_next = fr_state;
      err_set = 1'b0;
      if (wr_fire) begin
         case (fr_state)
            FR_EXPECT_HDR: begin
               if (!receive_is_header)   err_set = 1'b1;
               else if (!receive_is_tail) fr_next = FR_IN_PKT;
            end
            FR_IN_PKT: begin
               if (receive_is_header) err_set = 1'b1;
               if (receive_is_tail)   fr_next = FR_EXPECT_HDR;
            end
            default: fr_next = FR_EXPECT_HDR;
         endcase
      end
   end

endmodule

// File: tb/tb_noc_packet_buffer_node.sv
// Directed bench for noc_packet_buffer_node: stimulus pushes expected flits
// into a queue, a negedge monitor pops and compares every delivered flit.
module tb_noc_packet_buffer_node;

   logic       noc_clk = 1'b0;
   logic       noc_rst_n;
   logic       receive_valid;
   logic       receive_ready;
   logic [7:0] receive_flit;
   logic       receive_is_header;
   logic       receive_is_tail;
   logic       sender_valid;
   logic       sender_ready;
   logic [7:0] sender_flit;
   logic       sender_is_header;
   logic       sender_is_tail;
   logic [4:0] pkt_count;
   logic       proto_err;

   int total = 0;
   int bad   = 0;
   logic [9:0] exp_q [$];

   noc_packet_buffer_node #(.DATA_WIDTH(8), .DEPTH(16)) dut (
      .noc_clk(noc_clk), .noc_rst_n(noc_rst_n),
      .receive_valid(receive_valid), .receive_ready(receive_ready),
      .receive_flit(receive_flit), .receive_is_header(receive_is_header),
      .receive_is_tail(receive_is_tail),
      .sender_valid(sender_valid), .sender_ready(sender_ready),
      .sender_flit(sender_flit), .sender_is_header(sender_is_header),
      .sender_is_tail(sender_is_tail),
      .pkt_count(pkt_count), .proto_err(proto_err)
   );

   always #5 noc_clk = ~noc_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every downstream handshake must match the oldest expected flit.
   always @(negedge noc_clk) begin
      if (noc_rst_n && sender_valid && sender_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL out_unexpected: got %0h/%0b/%0b expected none", sender_flit,
                     sender_is_header, sender_is_tail);
         end else begin
            chk("out_flit", {22'd0, sender_flit, sender_is_header, sender_is_tail},
                {22'd0, exp_q.pop_front()});
         end
      end
   end

   // Offer one flit until accepted; optionally confirm nothing is presented yet.
   task automatic send(input logic [7:0] d, input logic h, input logic t, input bit chk_sv);
      bit done = 1'b0;
      int n = 0;
      receive_valid = 1'b1; receive_flit = d; receive_is_header = h; receive_is_tail = t;
      while (!done && n < 200) begin
         @(negedge noc_clk);
         if (chk_sv) chk("no_early_valid", {31'd0, sender_valid}, 32'd0);
         if (receive_ready) begin
            exp_q.push_back({d, h, t});
            done = 1'b1;
         end
         @(posedge noc_clk); #1;
         n++;
      end
      receive_valid = 1'b0;
      chk("send_accepted", {31'd0, done}, 32'd1);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || sender_valid) && n < budget) begin
         @(posedge noc_clk); #1;
         n++;
      end
      chk("drain_in_budget", {31'd0, n < budget}, 32'd1);
   endtask

   task automatic do_reset();
      @(posedge noc_clk); #1;
      noc_rst_n = 1'b0;
      @(posedge noc_clk); #1;
      exp_q.delete();
      @(posedge noc_clk); #1;
      noc_rst_n = 1'b1;
   endtask

   initial begin
      noc_rst_n = 1'b0; receive_valid = 1'b0; receive_flit = '0;
      receive_is_header = 1'b0; receive_is_tail = 1'b0; sender_ready = 1'b0;
      repeat (3) @(posedge noc_clk);
      @(negedge noc_clk);
      chk("rst_receive_ready", {31'd0, receive_ready}, 32'd0);
      chk("rst_sender_valid", {31'd0, sender_valid}, 32'd0);
      chk("rst_pkt_count", {27'd0, pkt_count}, 32'd0);
      chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
      @(posedge noc_clk); #1;
      noc_rst_n = 1'b1;
      @(negedge noc_clk);
      chk("ready_after_release", {31'd0, receive_ready}, 32'd1);
      @(posedge noc_clk); #1;

      // 1: single-flit packet, valid one cycle after the write
      sender_ready = 1'b1;
      send(8'hA5, 1'b1, 1'b1, 1'b0);
      @(negedge noc_clk);
      chk("t1_valid", {31'd0, sender_valid}, 32'd1);
      chk("t1_pkt_count_1", {27'd0, pkt_count}, 32'd1);
      @(posedge noc_clk); #1;
      @(negedge noc_clk);
      chk("t1_pkt_count_0", {27'd0, pkt_count}, 32'd0);
      chk("t1_idle", {31'd0, sender_valid}, 32'd0);
      @(posedge noc_clk); #1;

      // 2: 4-flit packet held until tail, then back-to-back
      send(8'h00, 1'b1, 1'b0, 1'b1);
      send(8'h01, 1'b0, 1'b0, 1'b1);
      send(8'h02, 1'b0, 1'b0, 1'b1);
      send(8'h03, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge noc_clk);
         chk("t2_back_to_back", {31'd0, sender_valid}, 32'd1);
         @(posedge noc_clk); #1;
      end
      @(negedge noc_clk);
      chk("t2_done", {31'd0, sender_valid}, 32'd0);
      @(posedge noc_clk); #1;

      // 3: fill with four 4-flit packets, pointers wrap during the drain
      sender_ready = 1'b0;
      for (int p = 0; p < 4; p++)
         for (int f = 0; f < 4; f++)
            send(8'(8'h10 + p * 4 + f), f == 0, f == 3, 1'b0);
      receive_valid = 1'b1; receive_flit = 8'hEE; receive_is_header = 1'b1; receive_is_tail = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge noc_clk);
         chk("t3_full_not_ready", {31'd0, receive_ready}, 32'd0);
         @(posedge noc_clk); #1;
      end
      receive_valid = 1'b0;
      @(negedge noc_clk);
      chk("t3_pkt_count_4", {27'd0, pkt_count}, 32'd4);
      chk("t3_valid_held", {31'd0, sender_valid}, 32'd1);
      @(posedge noc_clk); #1;
      sender_ready = 1'b1;
      drain(60);
      chk("t3_pkt_count_0", {27'd0, pkt_count}, 32'd0);

      // 4: oversized packet goes cut-through, then back to store mode
      for (int f = 0; f < 20; f++)
         send(8'(8'h40 + f), f == 0, f == 19, 1'b0);
      drain(60);
      chk("t4_pkt_count_0", {27'd0, pkt_count}, 32'd0);
      send(8'h70, 1'b1, 1'b0, 1'b0);
      @(negedge noc_clk);
      chk("t4_store_again", {31'd0, sender_valid}, 32'd0);
      @(posedge noc_clk); #1;
      send(8'h71, 1'b0, 1'b1, 1'b0);
      drain(20);
      chk("t4_no_err", {31'd0, proto_err}, 32'd0);

      // 5a: body flits with no header
      send(8'h80, 1'b0, 1'b0, 1'b0);
      @(negedge noc_clk);
      chk("t5_err_no_hdr", {31'd0, proto_err}, 32'd1);
      @(posedge noc_clk); #1;
      send(8'h81, 1'b0, 1'b1, 1'b0);
      send(8'h82, 1'b1, 1'b1, 1'b0);
      drain(20);
      chk("t5_err_sticky", {31'd0, proto_err}, 32'd1);
      do_reset();
      @(negedge noc_clk);
      chk("t5_err_cleared", {31'd0, proto_err}, 32'd0);
      @(posedge noc_clk); #1;

      // 5b: header inside an open packet
      send(8'h90, 1'b1, 1'b0, 1'b0);
      @(negedge noc_clk);
      chk("t5_open_ok", {31'd0, proto_err}, 32'd0);
      @(posedge noc_clk); #1;
      send(8'h91, 1'b1, 1'b0, 1'b0);
      send(8'h92, 1'b0, 1'b1, 1'b0);
      drain(20);
      repeat (3) @(posedge noc_clk);
      @(negedge noc_clk);
      chk("t5_err_nested_hdr", {31'd0, proto_err}, 32'd1);
      @(posedge noc_clk); #1;

      // 6: reset with packets buffered discards them
      sender_ready = 1'b0;
      send(8'hB0, 1'b1, 1'b0, 1'b0);
      send(8'hB1, 1'b0, 1'b1, 1'b0);
      send(8'hB2, 1'b1, 1'b0, 1'b0);
      send(8'hB3, 1'b0, 1'b1, 1'b0);
      @(negedge noc_clk);
      chk("t6_pkt_count_2", {27'd0, pkt_count}, 32'd2);
      @(posedge noc_clk); #1;
      noc_rst_n = 1'b0;
      @(posedge noc_clk); #1;
      @(negedge noc_clk);
      chk("t6_rst_valid", {31'd0, sender_valid}, 32'd0);
      chk("t6_rst_pkt_count", {27'd0, pkt_count}, 32'd0);
      chk("t6_rst_ready", {31'd0, receive_ready}, 32'd0);
      exp_q.delete();
      @(posedge noc_clk); #1;
      noc_rst_n = 1'b1;
      sender_ready = 1'b1;
      @(negedge noc_clk);
      chk("t6_ready_after", {31'd0, receive_ready}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("t6_no_stale", {31'd0, sender_valid}, 32'd0);
         @(negedge noc_clk);
      end
      @(posedge noc_clk); #1;
      send(8'hC7, 1'b1, 1'b1, 1'b0);
      drain(20);
      chk("queue_empty", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
